// File: rtl/lane_fifo_block_sched_pkg.sv
// Shared definitions for the lane FIFO block scheduler: requester indices,
// requester count and FSM state encoding.
package lane_fifo_block_sched_pkg;

  localparam int NUM_REQ   = 3;
  localparam int REQ_GT    = 0;
  localparam int REQ_DQDQS = 1;
  localparam int REQ_APB   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLOCK,
    ST_GRANT,
    ST_FLUSH
  } state_t;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/lane_fifo_block_sched_rr_arbiter3.sv
// Combinational round-robin pick among three requesters; search starts at
// the requester after the last granted one.
module rr_arbiter3
  import lane_fifo_block_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               valid,
  output logic [1:0]         idx
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    valid = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!valid && req[(int'(last) + i) % NUM_REQ]) begin
        valid = 1'b1;
        idx   = 2'((int'(last) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/lane_fifo_block_sched.sv
// Read-path ownership scheduler: block lanes, drain, grant, flush on release.
// Optional grant watchdog enabled by defining LANE_BLK_TIMEOUT_EN.
module lane_fifo_block_sched
  import lane_fifo_block_sched_pkg::*;
#(
  parameter int IOG_DQS_LANES  = 2,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                SCLK,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*IOG_DQS_LANES-1:0]    req_lane_mask,
  input  logic [IOG_DQS_LANES-1:0]            entries_in_fifo,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [IOG_DQS_LANES-1:0]            block_fifo,
  output logic                                fifo_flush_n,
  output logic                                busy,
  output logic                                timeout
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);

  state_t                   state, state_nx;
  logic [1:0]               winner, last;
  logic [IOG_DQS_LANES-1:0] active_mask, mask_nx, arb_mask;
  logic [CW-1:0]            cnt;
  logic [NUM_REQ-1:0]       req_eff;
  logic                     arb_valid;
  logic [1:0]               arb_idx;
  logic                     timeout_hit;
  logic                     enter_block, enter_flush, enter_grant;

  rr_arbiter3 u_arb (
    .req   (req_eff),
    .last  (last),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

`ifdef LANE_BLK_TIMEOUT_EN
  logic [15:0]        tcnt;
  logic [NUM_REQ-1:0] lock;

  // A timed-out requester stays locked out until it drops its request.
  assign req_eff     = req & ~lock;
  assign timeout_hit = (state == ST_GRANT) && (tcnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge SCLK) begin
    if (!reset_n) begin
      tcnt    <= '0;
      lock    <= '0;
      timeout <= 1'b0;
    end else begin
      if (enter_grant)             tcnt <= '0;
      else if (state == ST_GRANT)  tcnt <= tcnt + 16'd1;
      lock <= (lock & req) | (timeout_hit ? req_onehot(winner) : '0);
      if (timeout_hit) timeout <= 1'b1;
    end
  end
`else
  assign req_eff     = req;
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  // A zero mask from a requester means it owns every lane.
  assign arb_mask = (req_lane_mask[arb_idx*IOG_DQS_LANES +: IOG_DQS_LANES] == '0)
                    ? '1 : req_lane_mask[arb_idx*IOG_DQS_LANES +: IOG_DQS_LANES];
  assign mask_nx  = (state == ST_IDLE && arb_valid) ? arb_mask : active_mask;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (arb_valid) state_nx = ST_BLOCK;
      ST_BLOCK: begin
        if (!req[winner])
          state_nx = ST_FLUSH;
        else if (cnt == '0 && (entries_in_fifo & active_mask) == '0)
          state_nx = ST_GRANT;
      end
      ST_GRANT: if (!req[winner] || timeout_hit) state_nx = ST_FLUSH;
      ST_FLUSH: if (cnt == '0) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign enter_block = (state_nx == ST_BLOCK) && (state != ST_BLOCK);
  assign enter_flush = (state_nx == ST_FLUSH) && (state != ST_FLUSH);
  assign enter_grant = (state_nx == ST_GRANT) && (state != ST_GRANT);

  always_ff @(posedge SCLK) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      winner       <= 2'd0;
      last         <= 2'(REQ_APB);
      active_mask  <= '0;
      cnt          <= '0;
      gnt          <= '0;
      block_fifo   <= '0;
      fifo_flush_n <= 1'b1;
      busy         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state       <= state_nx;
      active_mask <= mask_nx;
      if (state == ST_IDLE && arb_valid) winner <= arb_idx;
      if (enter_grant) last <= winner;

      if (enter_block || enter_flush) cnt <= DRAIN_LOAD;
      else if (cnt != '0)             cnt <= cnt - 1'b1;

      // Outputs are registered from next-state so they line up with the FSM.
      gnt          <= (state_nx == ST_GRANT) ? req_onehot(winner) : '0;
      block_fifo   <= (state_nx == ST_IDLE) ? '0 : mask_nx;
      fifo_flush_n <= !enter_flush;
      busy         <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_lane_fifo_block_sched.sv
// Directed bench for lane_fifo_block_sched: vector table plus multi-cycle
// sequences; timeout sequence active when LANE_BLK_TIMEOUT_EN is defined.
module tb_lane_fifo_block_sched;

  logic       SCLK = 1'b0;
  logic       reset_n;
  logic [2:0] req;
  logic [5:0] req_lane_mask;
  logic [1:0] entries_in_fifo;
  logic [2:0] gnt;
  logic [1:0] block_fifo;
  logic       fifo_flush_n;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  lane_fifo_block_sched #(
    .IOG_DQS_LANES  (2),
    .DRAIN_CYCLES   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .SCLK            (SCLK),
    .reset_n         (reset_n),
    .req             (req),
    .req_lane_mask   (req_lane_mask),
    .entries_in_fifo (entries_in_fifo),
    .gnt             (gnt),
    .block_fifo      (block_fifo),
    .fifo_flush_n    (fifo_flush_n),
    .busy            (busy),
    .timeout         (timeout)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    logic [2:0] req;
    logic [5:0] mask;
    logic [1:0] ent;
    logic [2:0] gnt;
    logic [1:0] blk;
    logic       fl;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; req_lane_mask = '0; entries_in_fifo = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic add(input logic [2:0] r, input logic [5:0] m, input logic [1:0] e,
                     input logic [2:0] g, input logic [1:0] b, input logic f, input logic bz);
    vec_t v;
    v.req = r; v.mask = m; v.ent = e; v.gnt = g; v.blk = b; v.fl = f; v.busy = bz;
    vecs.push_back(v);
  endtask

  task automatic wait_gnt(input string nm);
    int n = 0;
    while (gnt == 3'b000 && n < 100) begin tick(); n++; end
    check({nm, "_gnt_seen"}, 32'(gnt != 3'b000), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check({nm, "_idle_seen"}, 32'(busy), 32'd0);
  endtask

  initial begin
    do_reset();
    check("reset_outputs", {gnt, block_fifo, fifo_flush_n, busy, timeout}, {3'b000, 2'b00, 1'b1, 1'b0, 1'b0});

    // Single owner, lane 1 busy but outside mask; then mask change ignored in GRANT.
    add(3'b001, 6'b000001, 2'b10, 3'b000, 2'b01, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) add(3'b001, 6'b000001, 2'b10, 3'b000, 2'b01, 1'b1, 1'b1);
    add(3'b001, 6'b000001, 2'b10, 3'b001, 2'b01, 1'b1, 1'b1);
    add(3'b001, 6'b000011, 2'b00, 3'b001, 2'b01, 1'b1, 1'b1);
    add(3'b000, 6'b000011, 2'b00, 3'b000, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add(3'b000, 6'b000000, 2'b00, 3'b000, 2'b01, 1'b1, 1'b1);
    add(3'b000, 6'b000000, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0);
    // APB with zero mask owns both lanes.
    add(3'b100, 6'b000000, 2'b00, 3'b000, 2'b11, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) add(3'b100, 6'b000000, 2'b00, 3'b000, 2'b11, 1'b1, 1'b1);
    add(3'b100, 6'b000000, 2'b00, 3'b100, 2'b11, 1'b1, 1'b1);
    add(3'b000, 6'b000000, 2'b00, 3'b000, 2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add(3'b000, 6'b000000, 2'b00, 3'b000, 2'b11, 1'b1, 1'b1);
    add(3'b000, 6'b000000, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      req = vecs[i].req; req_lane_mask = vecs[i].mask; entries_in_fifo = vecs[i].ent;
      tick();
      check($sformatf("vec%0d", i), {gnt, block_fifo, fifo_flush_n, busy},
            {vecs[i].gnt, vecs[i].blk, vecs[i].fl, vecs[i].busy});
    end

    // Round robin between DQ/DQS and APB right after reset.
    begin
      logic [2:0] exp_g [3];
      exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b010;
      do_reset();
      req_lane_mask = 6'b010100;
      req = 3'b110;
      for (int r = 0; r < 3; r++) begin
        wait_gnt($sformatf("rr%0d", r));
        check($sformatf("rr%0d_gnt", r), gnt, exp_g[r]);
        req = req & ~gnt;
        tick();
        req = 3'b110;
        wait_idle($sformatf("rr%0d", r));
        check($sformatf("rr%0d_block_gap", r), block_fifo, 2'b00);
      end
      req = '0;
      wait_idle("rr_end");
    end

    // Occupied lane inside the mask holds off the grant.
    begin
      int early = 0;
      do_reset();
      req_lane_mask = 6'b000011;
      entries_in_fifo = 2'b10;
      req = 3'b001;
      tick();
      check("ent_block", block_fifo, 2'b11);
      for (int i = 0; i < 10; i++) begin
        tick();
        if (gnt != 3'b000) early++;
      end
      check("ent_no_early_gnt", early, 0);
      entries_in_fifo = 2'b00;
      tick();
      check("ent_gnt_after_clear", gnt, 3'b001);
      req = '0;
      wait_idle("ent");
    end

    // Winner withdraws during BLOCK: no grant, one flush pulse.
    begin
      int pulses = 0, grants = 0, n = 0;
      do_reset();
      req_lane_mask = 6'b001000;
      req = 3'b010;
      tick();
      check("drop_block", block_fifo, 2'b10);
      tick();
      req = '0;
      tick();
      check("drop_flush", {gnt, fifo_flush_n, busy}, {3'b000, 1'b0, 1'b1});
      pulses = 1;
      while (busy && n < 20) begin
        tick(); n++;
        if (!fifo_flush_n) pulses++;
        if (gnt != 3'b000) grants++;
      end
      check("drop_pulses", pulses, 1);
      check("drop_grants", grants, 0);
      check("drop_idle", {busy, block_fifo}, {1'b0, 2'b00});
    end

    // Reset while granted.
    begin
      do_reset();
      req_lane_mask = 6'b000001;
      req = 3'b001;
      wait_gnt("rst");
`ifndef LANE_BLK_TIMEOUT_EN
      for (int i = 0; i < 20; i++) tick();
      check("rst_grant_held", {gnt, timeout}, {3'b001, 1'b0});
`endif
      reset_n = 1'b0;
      tick();
      check("rst_in_grant", {gnt, block_fifo, fifo_flush_n, busy, timeout},
            {3'b000, 2'b00, 1'b1, 1'b0, 1'b0});
      req = '0;
      reset_n = 1'b1;
      tick();
    end

`ifdef LANE_BLK_TIMEOUT_EN
    // Stuck requester hits the watchdog and is locked out until it drops req.
    begin
      int held = 0, regrants = 0;
      do_reset();
      req_lane_mask = 6'b000001;
      req = 3'b001;
      wait_gnt("tmo");
      while (gnt != 3'b000 && held < 50) begin tick(); held++; end
      check("tmo_gnt_cycles", held, 8);
      check("tmo_flag", {gnt, timeout, fifo_flush_n}, {3'b000, 1'b1, 1'b0});
      for (int i = 0; i < 20; i++) begin
        tick();
        if (gnt != 3'b000) regrants++;
      end
      check("tmo_lockout", regrants, 0);
      req = '0;
      tick();
      req = 3'b001;
      wait_gnt("tmo_regrant");
      check("tmo_sticky", timeout, 1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
